skindet_ctrl: RTL

- Control and statistics block for the skin-detection pipeline.
- Holds the Cb/Cr window thresholds behind a simple register bus, double-buffered so new values take effect only at a frame boundary.
- Counts skin pixels per frame from the detector's binary output, latches the result at frame end and raises an interrupt.
- Sits beside the detector: drives its threshold inputs and observes its output and sync signals.

---
 rtl/skindet_pkg.sv | 31 +++
 rtl/skindet_bbox.sv | 76 +++++++
 rtl/skindet_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/skindet_pkg.sv
// Shared definitions for the skin-detector control block: register map, bit
// positions, FSM states and default thresholds.
package skindet_pkg;

    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_TAB    = 3'd1;
    localparam logic [2:0] ADDR_TCD    = 3'd2;
    localparam logic [2:0] ADDR_STATUS = 3'd3;
    localparam logic [2:0] ADDR_COUNT  = 3'd4;
    localparam logic [2:0] ADDR_BBOX_X = 3'd5;
    localparam logic [2:0] ADDR_BBOX_Y = 3'd6;
    localparam logic [2:0] ADDR_FRAMES = 3'd7;

    localparam int CTRL_EN_BIT         = 0;
    localparam int CTRL_COMMIT_BIT     = 1;
    localparam int CTRL_IRQ_EN_BIT     = 2;
    localparam int STATUS_IN_FRAME_BIT = 0;
    localparam int STATUS_DONE_BIT     = 1;

    localparam logic [7:0] TA_DEF = 8'd20;
    localparam logic [7:0] TB_DEF = 8'd120;
    localparam logic [7:0] TC_DEF = 8'd20;
    localparam logic [7:0] TD_DEF = 8'd150;

    typedef enum logic [1:0] {
        WAIT   = 2'd0,
        ACTIVE = 2'd1,
        COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/skindet_bbox.sv
// Skin bounding-box tracker: column/row counters plus per-frame min/max of skin
// pixel coordinates, latched at commit. Only instantiated under SKINDET_CTRL_BBOX_EN.
module skindet_bbox #(
    parameter int unsigned X_W = 12,
    parameter int unsigned Y_W = 12
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           fv_i,
    input  logic           lv_i,
    input  logic           skin_i,
    input  logic           start_i,
    input  logic           active_i,
    input  logic           commit_i,
    output logic [X_W-1:0] xmin_o,
    output logic [X_W-1:0] xmax_o,
    output logic [Y_W-1:0] ymin_o,
    output logic [Y_W-1:0] ymax_o
);

    logic [X_W-1:0] x_q, xmin_q, xmax_q, xmin_lat_q, xmax_lat_q;
    logic [Y_W-1:0] y_q, ymin_q, ymax_q, ymin_lat_q, ymax_lat_q;
    logic           lv_d_q;
    logic           pix;

    assign pix = fv_i & lv_i & skin_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lv_d_q     <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            xmin_q     <= '1;
            xmax_q     <= '0;
            ymin_q     <= '1;
            ymax_q     <= '0;
            xmin_lat_q <= '0;
            xmax_lat_q <= '0;
            ymin_lat_q <= '0;
            ymax_lat_q <= '0;
        end else begin
            lv_d_q <= lv_i;
            x_q    <= (fv_i & lv_i) ? x_q + X_W'(1) : '0;
            if (!fv_i)
                y_q <= '0;
            else if (lv_d_q & ~lv_i)
                y_q <= y_q + Y_W'(1);

            // Tracker restarts with the first cycle of a counted frame, which may itself hold a skin pixel.
            if (start_i) begin
                xmin_q <= pix ? x_q : '1;
                xmax_q <= pix ? x_q : '0;
                ymin_q <= pix ? y_q : '1;
                ymax_q <= pix ? y_q : '0;
            end else if (active_i & pix) begin
                if (x_q < xmin_q) xmin_q <= x_q;
                if (x_q > xmax_q) xmax_q <= x_q;
                if (y_q < ymin_q) ymin_q <= y_q;
                if (y_q > ymax_q) ymax_q <= y_q;
            end

            if (commit_i) begin
                xmin_lat_q <= xmin_q;
                xmax_lat_q <= xmax_q;
                ymin_lat_q <= ymin_q;
                ymax_lat_q <= ymax_q;
            end
        end
    end

    assign xmin_o = xmin_lat_q;
    assign xmax_o = xmax_lat_q;
    assign ymin_o = ymin_lat_q;
    assign ymax_o = ymax_lat_q;

endmodule

// File: rtl/skindet_ctrl.sv
// Skin-detector control: double-buffered Cb/Cr thresholds, per-frame skin count and IRQ.
// Define SKINDET_CTRL_BBOX_EN to add the bounding-box tracker at addresses 5/6.
//
// state  | meaning
// WAIT   | idle until frame-valid rises with EN set
// ACTIVE | counting skin pixels of the current frame
// COMMIT | one cycle: latch results, apply pending thresholds
module skindet_ctrl
    import skindet_pkg::*;
#(
    parameter int unsigned CNT_W  = 22,
    parameter logic [7:0]  TA_RST = TA_DEF,
    parameter logic [7:0]  TB_RST = TB_DEF,
    parameter logic [7:0]  TC_RST = TC_DEF,
    parameter logic [7:0]  TD_RST = TD_DEF,
    parameter int unsigned X_W    = 12,
    parameter int unsigned Y_W    = 12
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic [2:0]  iAddr,
    input  logic        iWrite,
    input  logic [31:0] iWriteData,
    input  logic        iRead,
    output logic [31:0] oReadData,
    output logic        oReadValid,
    input  logic        iSkin,
    input  logic        iLineValid,
    input  logic        iFrameValid,
    output logic [7:0]  oTa,
    output logic [7:0]  oTb,
    output logic [7:0]  oTc,
    output logic [7:0]  oTd,
    output logic        oIrq
);

    state_t           state_q;
    logic             fv_d_q;
    logic [CNT_W-1:0] run_cnt_q, count_q, frames_q;
    logic [7:0]       ta_q, tb_q, tc_q, td_q;
    logic [7:0]       ta_sh_q, tb_sh_q, tc_sh_q, td_sh_q;
    logic             en_q, irq_en_q, pending_q, done_q, irq_q;
    logic [31:0]      rdata_q;
    logic             rvalid_q;

    logic rise, fall, pix, start, commit;
    logic wr_ctrl, wr_tab, wr_tcd, wr_status;
    logic done_d, irq_en_d;
    logic [31:0] rd_mux, bbox_x, bbox_y;
    logic [X_W-1:0] bx_min, bx_max;
    logic [Y_W-1:0] by_min, by_max;
    logic unused_wdata;

    assign rise   = iFrameValid & ~fv_d_q;
    assign fall   = ~iFrameValid & fv_d_q;
    assign pix    = iFrameValid & iLineValid & iSkin;
    assign commit = (state_q == COMMIT);
    // A frame is only counted when we see its start; one already running is skipped.
    assign start  = rise & en_q & (state_q != ACTIVE);

    assign wr_ctrl   = iWrite & (iAddr == ADDR_CTRL);
    assign wr_tab    = iWrite & (iAddr == ADDR_TAB);
    assign wr_tcd    = iWrite & (iAddr == ADDR_TCD);
    assign wr_status = iWrite & (iAddr == ADDR_STATUS);
    assign unused_wdata = ^iWriteData[31:16];

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q   <= WAIT;
            fv_d_q    <= 1'b0;
            run_cnt_q <= '0;
            count_q   <= '0;
            frames_q  <= '0;
        end else begin
            fv_d_q <= iFrameValid;
            case (state_q)
                WAIT: begin
                    if (start) begin
                        state_q   <= ACTIVE;
                        run_cnt_q <= CNT_W'(pix);
                    end
                end
                ACTIVE: begin
                    if (pix && (run_cnt_q != '1))
                        run_cnt_q <= run_cnt_q + CNT_W'(1);
                    if (fall)
                        state_q <= COMMIT;
                end
                COMMIT: begin
                    count_q  <= run_cnt_q;
                    frames_q <= frames_q + CNT_W'(1);
                    if (start) begin
                        state_q   <= ACTIVE;
                        run_cnt_q <= CNT_W'(pix);
                    end else begin
                        state_q <= WAIT;
                    end
                end
                default: state_q <= WAIT;
            endcase
        end
    end

    // Commit's set of done wins over a same-cycle write-1-to-clear.
    always_comb begin
        done_d = done_q;
        if (wr_status & iWriteData[STATUS_DONE_BIT])
            done_d = 1'b0;
        if (commit)
            done_d = 1'b1;
    end

    assign irq_en_d = wr_ctrl ? iWriteData[CTRL_IRQ_EN_BIT] : irq_en_q;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            ta_q      <= TA_RST;
            tb_q      <= TB_RST;
            tc_q      <= TC_RST;
            td_q      <= TD_RST;
            ta_sh_q   <= TA_RST;
            tb_sh_q   <= TB_RST;
            tc_sh_q   <= TC_RST;
            td_sh_q   <= TD_RST;
            en_q      <= 1'b0;
            irq_en_q  <= 1'b0;
            pending_q <= 1'b0;
            done_q    <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                en_q     <= iWriteData[CTRL_EN_BIT];
                irq_en_q <= iWriteData[CTRL_IRQ_EN_BIT];
            end
            if (wr_tab) {tb_sh_q, ta_sh_q} <= iWriteData[15:0];
            if (wr_tcd) {td_sh_q, tc_sh_q} <= iWriteData[15:0];
            if (commit & pending_q) begin
                ta_q <= ta_sh_q;
                tb_q <= tb_sh_q;
                tc_q <= tc_sh_q;
                td_q <= td_sh_q;
            end
            if (wr_ctrl & iWriteData[CTRL_COMMIT_BIT])
                pending_q <= 1'b1;
            else if (commit)
                pending_q <= 1'b0;
            done_q <= done_d;
            irq_q  <= done_d & irq_en_d;
        end
    end

`ifdef SKINDET_CTRL_BBOX_EN
    skindet_bbox #(
        .X_W(X_W),
        .Y_W(Y_W)
    ) u_bbox (
        .clk_i   (iClk),
        .rst_i   (iRst),
        .fv_i    (iFrameValid),
        .lv_i    (iLineValid),
        .skin_i  (iSkin),
        .start_i (start),
        .active_i(state_q == ACTIVE),
        .commit_i(commit),
        .xmin_o  (bx_min),
        .xmax_o  (bx_max),
        .ymin_o  (by_min),
        .ymax_o  (by_max)
    );
`else
    assign bx_min = '0;
    assign bx_max = '0;
    assign by_min = '0;
    assign by_max = '0;
`endif

    assign bbox_x = (32'(bx_max) << 16) | 32'(bx_min);
    assign bbox_y = (32'(by_max) << 16) | 32'(by_min);

    always_comb begin
        rd_mux = '0;
        case (iAddr)
            ADDR_CTRL: begin
                rd_mux[CTRL_EN_BIT]     = en_q;
                rd_mux[CTRL_COMMIT_BIT] = pending_q;
                rd_mux[CTRL_IRQ_EN_BIT] = irq_en_q;
            end
            ADDR_TAB: rd_mux[15:0] = {tb_sh_q, ta_sh_q};
            ADDR_TCD: rd_mux[15:0] = {td_sh_q, tc_sh_q};
            ADDR_STATUS: begin
                rd_mux[STATUS_IN_FRAME_BIT] = (state_q == ACTIVE);
                rd_mux[STATUS_DONE_BIT]     = done_q;
            end
            ADDR_COUNT:  rd_mux = 32'(count_q);
            ADDR_BBOX_X: rd_mux = bbox_x;
            ADDR_BBOX_Y: rd_mux = bbox_y;
            ADDR_FRAMES: rd_mux = 32'(frames_q);
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= iRead;
            if (iRead)
                rdata_q <= rd_mux;
        end
    end

    assign oReadData  = rdata_q;
    assign oReadValid = rvalid_q;
    assign oTa        = ta_q;
    assign oTb        = tb_q;
    assign oTc        = tc_q;
    assign oTd        = td_q;
    assign oIrq       = irq_q;

endmodule
